// File: rtl/register_file_wb_if.sv
// register_file_wb_if: decode/write-back signal bundle for the register file
interface register_file_wb_if;
  logic        WR;
  logic [31:0] WBData;
  logic [4:0]  Rd_WB;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [31:0] Bus1;
  logic [31:0] Bus2;
  logic        Issue;
  logic [4:0]  Rd_Issue;
  logic        Busy1;
  logic        Busy2;
  logic        Ovf;
  modport master (output WR, WBData, Rd_WB, Rs1, Rs2, Issue, Rd_Issue, input Bus1, Bus2, Busy1, Busy2, Ovf);
  modport slave (input WR, WBData, Rd_WB, Rs1, Rs2, Issue, Rd_Issue, output Bus1, Bus2, Busy1, Busy2, Ovf);
endinterface

// File: rtl/register_file_wb.sv
// register_file_wb: 32x32 register file with 2-bit pending-write scoreboard; REGFILE_BYPASS_EN forwards write-back data
module register_file_wb (
  input logic clk,
  input logic rst_n,
  register_file_wb_if.slave bus
);
  logic [31:0] regs [32];
  logic [1:0]  cnt [32];
  logic [31:0] inc, dec;
  logic        ovf, hit1, hit2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (bus.WR && bus.Rd_WB != 5'd0) regs[bus.Rd_WB] <= bus.WBData;
  always_comb begin
    inc = '0;
    dec = '0;
    inc[bus.Rd_Issue] = bus.Issue && bus.Rd_Issue != 5'd0 && cnt[bus.Rd_Issue] != 2'd3;
    dec[bus.Rd_WB] = bus.WR && bus.Rd_WB != 5'd0 && cnt[bus.Rd_WB] != 2'd0;
  end
  // inc and dec are guarded against wrap, and cancel when both hit one register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 32; i++) cnt[i] <= '0;
    else for (int i = 0; i < 32; i++) cnt[i] <= cnt[i] + 2'(inc[i]) - 2'(dec[i]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (bus.Issue && bus.Rd_Issue != 5'd0 && cnt[bus.Rd_Issue] == 2'd3) ovf <= 1'b1;
`ifdef REGFILE_BYPASS_EN
  assign hit1 = rst_n && bus.WR && bus.Rd_WB != 5'd0 && bus.Rd_WB == bus.Rs1;
  assign hit2 = rst_n && bus.WR && bus.Rd_WB != 5'd0 && bus.Rd_WB == bus.Rs2;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  assign bus.Bus1 = hit1 ? bus.WBData : regs[bus.Rs1];
  assign bus.Bus2 = hit2 ? bus.WBData : regs[bus.Rs2];
  assign bus.Busy1 = cnt[bus.Rs1] != 2'd0 && !(hit1 && cnt[bus.Rs1] == 2'd1);
  assign bus.Busy2 = cnt[bus.Rs2] != 2'd0 && !(hit2 && cnt[bus.Rs2] == 2'd1);
  assign bus.Ovf = ovf;
endmodule
